// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave bridging a host interconnect onto the on-chip REG_BUS.
// Writes become a single-cycle WREN; reads become a single-cycle RDEN followed
// by a bounded wait for RVLD. The write and read paths are fully independent.
module axil_reg_slave #(
  parameter int unsigned P_ADDR_WIDTH = 16,
  parameter int unsigned P_TIMEOUT    = 255
) (
  input  logic                    CLK,
  input  logic                    RST,
  // write address channel
  input  logic [31:0]             awaddr,
  input  logic [2:0]              awprot,
  input  logic                    awvalid,
  output logic                    awready,
  // write data channel
  input  logic [31:0]             wdata,
  input  logic [3:0]              wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  // write response channel
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  // read address channel
  input  logic [31:0]             araddr,
  input  logic [2:0]              arprot,
  input  logic                    arvalid,
  output logic                    arready,
  // read data channel
  output logic [31:0]             rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  // REG_BUS master side
  output logic                    WREN,
  output logic [P_ADDR_WIDTH-1:0] WADR,
  output logic [31:0]             WDAT,
  output logic                    RDEN,
  output logic [P_ADDR_WIDTH-1:0] RADR,
  input  logic [31:0]             RDAT,
  input  logic                    RVLD
);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_ISSUE = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_ISSUE = 2'd1;
  localparam logic [1:0] R_WAIT  = 2'd2;
  localparam logic [1:0] R_RESP  = 2'd3;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [31:0] ERR_DATA    = 32'hDEAD_BEEF;

  // Byte-address bits above the REG_BUS window; any of them set is an error.
  localparam logic [31:0] ADDR_OOB_MASK = ~((32'd1 << (P_ADDR_WIDTH + 2)) - 32'd1);
  // Counter value on the last R_WAIT cycle that may still accept RVLD.
  localparam logic [15:0] TIMEOUT_LAST  = 16'(P_TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  logic [1:0]              w_state_q, w_state_d;
  logic                    aw_held_q, aw_held_d;
  logic                    w_held_q, w_held_d;
  logic [31:0]             awaddr_q, awaddr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [P_ADDR_WIDTH-1:0] wadr_q, wadr_d;
  logic [31:0]             wdat_q, wdat_d;
  logic [1:0]              bresp_q, bresp_d;

  logic        aw_hs, w_hs, w_err;
  logic [31:0] aw_sel, w_sel;
  logic [3:0]  strb_sel;

  assign awready = ~RST & (w_state_q == W_IDLE) & ~aw_held_q;
  assign wready  = ~RST & (w_state_q == W_IDLE) & ~w_held_q;
  assign bvalid  = ~RST & (w_state_q == W_RESP);
  assign WREN    = ~RST & (w_state_q == W_ISSUE);
  assign bresp   = bresp_q;
  assign WADR    = wadr_q;
  assign WDAT    = wdat_q;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  // Use the live channel value in the cycle it is accepted, else the held copy,
  // so the decision can be made in the same cycle as the last handshake.
  assign aw_sel   = aw_held_q ? awaddr_q : awaddr;
  assign w_sel    = w_held_q ? wdata_q : wdata;
  assign strb_sel = w_held_q ? wstrb_q : wstrb;
  assign w_err    = (strb_sel != 4'hF) | (|(aw_sel & ADDR_OOB_MASK));

  // Write FSM next state: capture AW/W independently, then issue or reject.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wadr_d    = wadr_q;
    wdat_d    = wdat_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = wdata;
          wstrb_d  = wstrb;
        end
        if ((aw_held_q | aw_hs) & (w_held_q | w_hs)) begin
          if (w_err) begin
            w_state_d = W_RESP;
            bresp_d   = RESP_SLVERR;
          end else begin
            w_state_d = W_ISSUE;
            wadr_d    = aw_sel[P_ADDR_WIDTH+1:2];
            wdat_d    = w_sel;
          end
        end
      end
      W_ISSUE: begin
        w_state_d = W_RESP;
        bresp_d   = RESP_OKAY;
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write path registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wadr_q    <= '0;
      wdat_q    <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wadr_q    <= wadr_d;
      wdat_q    <= wdat_d;
      bresp_q   <= bresp_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [1:0]              r_state_q, r_state_d;
  logic [P_ADDR_WIDTH-1:0] radr_q, radr_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    ar_hs;

  assign arready = ~RST & (r_state_q == R_IDLE);
  assign rvalid  = ~RST & (r_state_q == R_RESP);
  assign RDEN    = ~RST & (r_state_q == R_ISSUE);
  assign RADR    = radr_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  assign ar_hs = arvalid & arready;

  // Read FSM next state: issue RDEN, wait for RVLD with timeout, respond.
  always_comb begin
    r_state_d = r_state_q;
    radr_d    = radr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    cnt_d     = cnt_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          if (|(araddr & ADDR_OOB_MASK)) begin
            r_state_d = R_RESP;
            rresp_d   = RESP_SLVERR;
            rdata_d   = ERR_DATA;
          end else begin
            r_state_d = R_ISSUE;
            radr_d    = araddr[P_ADDR_WIDTH+1:2];
          end
        end
      end
      R_ISSUE: begin
        cnt_d = '0;
        if (RVLD) begin
          r_state_d = R_RESP;
          rdata_d   = RDAT;
          rresp_d   = RESP_OKAY;
        end else begin
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (RVLD) begin
          r_state_d = R_RESP;
          rdata_d   = RDAT;
          rresp_d   = RESP_OKAY;
        end else if (cnt_q == TIMEOUT_LAST) begin
          r_state_d = R_RESP;
          rdata_d   = ERR_DATA;
          rresp_d   = RESP_SLVERR;
        end
      end
      R_RESP: begin
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read path registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state_q <= R_IDLE;
      radr_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      cnt_q     <= '0;
    end else begin
      r_state_q <= r_state_d;
      radr_q    <= radr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      cnt_q     <= cnt_d;
    end
  end

  // Protection bits and byte-lane address bits carry no meaning on REG_BUS.
  logic unused_bits;
  assign unused_bits = ^{awprot, arprot, aw_sel[1:0], araddr[1:0]};

endmodule

// File: tb/tb_axil_reg_slave.sv
// Randomized self-checking bench for axil_reg_slave. A small REG_BUS register
// file model answers RDEN and supplies expected read data; transaction timing
// is checked against the latency rules of the bridge.
module tb_axil_reg_slave;

  localparam int AW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   awaddr, wdata, araddr, rdata, WDAT, RDAT;
  logic [2:0]    awprot, arprot;
  logic [3:0]    wstrb;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [1:0]    bresp, rresp;
  logic          WREN, RDEN, RVLD;
  logic [AW-1:0] WADR, RADR;

  axil_reg_slave #(
    .P_ADDR_WIDTH(AW),
    .P_TIMEOUT   (TO)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .awaddr (awaddr),
    .awprot (awprot),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wvalid (wvalid),
    .wready (wready),
    .bresp  (bresp),
    .bvalid (bvalid),
    .bready (bready),
    .araddr (araddr),
    .arprot (arprot),
    .arvalid(arvalid),
    .arready(arready),
    .rdata  (rdata),
    .rresp  (rresp),
    .rvalid (rvalid),
    .rready (rready),
    .WREN   (WREN),
    .WADR   (WADR),
    .WDAT   (WDAT),
    .RDEN   (RDEN),
    .RADR   (RADR),
    .RDAT   (RDAT),
    .RVLD   (RVLD)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int wren_at  = -1;
  int rden_at  = -1;

  // REG_BUS register file model.
  logic [31:0] regs [logic [AW-1:0]];

  function automatic logic [31:0] model_rd(input logic [AW-1:0] a);
    if (regs.exists(a)) return regs[a];
    return {a, ~a};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One write; delays are in cycles from the call, b_dly < 0 keeps bready high.
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly,
                           input int b_dly);
    bit            err, done, ready_bad, bv_drop;
    logic [AW-1:0] exp_adr, got_adr;
    logic [31:0]   got_dat;
    logic [1:0]    got_bresp;
    int k, n_aw, n_w, n_last, wren_cyc, wren_cnt, bv_cyc, b_hs;
    err = (strb != 4'hF) || (addr[31:AW+2] != '0);
    exp_adr = addr[AW+1:2];
    k = 0; n_aw = -1; n_w = -1; wren_cyc = -1; wren_cnt = 0; bv_cyc = -1; b_hs = -1;
    done = 0; ready_bad = 0; bv_drop = 0;
    got_adr = '0; got_dat = '0; got_bresp = '0;
    while (!done && k < 200) begin
      awaddr  = addr;
      wdata   = data;
      wstrb   = strb;
      awprot  = 3'($urandom);
      awvalid = (n_aw < 0) && (k >= aw_dly);
      wvalid  = (n_w < 0) && (k >= w_dly);
      if (WREN) begin
        wren_cnt++;
        if (wren_cyc < 0) begin
          wren_cyc = k; got_adr = WADR; got_dat = WDAT; wren_at = cyc;
        end
      end
      if (bvalid && bv_cyc < 0) begin
        bv_cyc = k; got_bresp = bresp;
      end
      if (bv_cyc >= 0 && b_hs < 0 && !bvalid) bv_drop = 1;
      if (b_hs < 0 && ((n_aw >= 0 && awready) || (n_w >= 0 && wready))) ready_bad = 1;
      bready = (b_hs < 0) && ((b_dly < 0) || (bv_cyc >= 0 && k - bv_cyc >= b_dly));
      if (awvalid && awready) n_aw = k;
      if (wvalid && wready) n_w = k;
      if (b_hs >= 0 && k == b_hs + 1) begin
        check_val("wr_bvalid_clear", {31'd0, bvalid}, 32'd0);
        done = 1;
      end else if (bvalid && bready && b_hs < 0) begin
        b_hs = k;
      end
      @(negedge clk);
      k++;
    end
    awvalid = 0; wvalid = 0; bready = 0;
    if (!done) check_val("wr_timeout", 32'd0, 32'd1);
    n_last = (n_aw > n_w) ? n_aw : n_w;
    if (err) begin
      check_val("wr_err_nowren", wren_cnt, 0);
      check_val("wr_err_bvalid_lat", bv_cyc, n_last + 1);
      check_val("wr_err_bresp", {30'd0, got_bresp}, 32'd2);
    end else begin
      check_val("wren_cnt", wren_cnt, 1);
      check_val("wren_lat", wren_cyc, n_last + 1);
      check_val("wadr", {16'd0, got_adr}, {16'd0, exp_adr});
      check_val("wdat", got_dat, data);
      check_val("bvalid_lat", bv_cyc, n_last + 2);
      check_val("bresp", {30'd0, got_bresp}, 32'd0);
      check_val("wadr_hold", {16'd0, WADR}, {16'd0, exp_adr});
      regs[exp_adr] = data;
    end
    check_val("bvalid_held", {31'd0, bv_drop}, 32'd0);
    check_val("wr_ready_low", {31'd0, ready_bad}, 32'd0);
  endtask

  // One read; rv_dly is RVLD delay after RDEN (< 0: never), r_dly < 0 keeps rready high.
  task automatic read_txn(input logic [31:0] addr, input int ar_dly, input int rv_dly,
                          input int r_dly);
    bit            err, done, unstable, extra;
    logic [AW-1:0] exp_adr, got_radr;
    logic [31:0]   got_rdata, exp_data;
    logic [1:0]    got_rresp;
    int k, n_ar, rden_cyc, rden_cnt, rv_cyc, rv_seen, r_hs;
    err = addr[31:AW+2] != '0;
    exp_adr = addr[AW+1:2];
    exp_data = model_rd(exp_adr);
    k = 0; n_ar = -1; rden_cyc = -1; rden_cnt = 0; rv_cyc = -1; rv_seen = -1; r_hs = -1;
    done = 0; unstable = 0; extra = 0;
    got_radr = '0; got_rdata = '0; got_rresp = '0;
    while (!done && k < 200) begin
      araddr  = addr;
      arprot  = 3'($urandom);
      arvalid = (n_ar < 0) && (k >= ar_dly);
      if (RDEN) begin
        rden_cnt++;
        if (rden_cyc < 0) begin
          rden_cyc = k; got_radr = RADR; rden_at = cyc;
          rv_cyc = (rv_dly >= 0) ? k + rv_dly : -1;
        end
      end
      RVLD = (rv_cyc >= 0) && (k == rv_cyc);
      RDAT = RVLD ? exp_data : $urandom;
      if (rvalid && r_hs >= 0) extra = 1;
      if (rvalid && rv_seen < 0) begin
        rv_seen = k; got_rdata = rdata; got_rresp = rresp;
      end
      if (rv_seen >= 0 && r_hs < 0 && (!rvalid || rdata !== got_rdata || rresp !== got_rresp))
        unstable = 1;
      rready = (r_hs < 0) && ((r_dly < 0) || (rv_seen >= 0 && k - rv_seen >= r_dly));
      if (arvalid && arready) n_ar = k;
      if (r_hs >= 0 && k > r_hs && k > rv_cyc + 1) done = 1;
      else if (rvalid && rready && r_hs < 0) r_hs = k;
      @(negedge clk);
      k++;
    end
    arvalid = 0; rready = 0; RVLD = 0;
    if (!done) check_val("rd_timeout", 32'd0, 32'd1);
    if (err) begin
      check_val("rd_err_norden", rden_cnt, 0);
      check_val("rd_err_rvalid_lat", rv_seen, n_ar + 1);
      check_val("rd_err_rresp", {30'd0, got_rresp}, 32'd2);
      check_val("rd_err_rdata", got_rdata, 32'hDEAD_BEEF);
    end else begin
      check_val("rden_cnt", rden_cnt, 1);
      check_val("rden_lat", rden_cyc, n_ar + 1);
      check_val("radr", {16'd0, got_radr}, {16'd0, exp_adr});
      if (rv_dly >= 0 && rv_dly <= TO) begin
        check_val("rvalid_lat", rv_seen, n_ar + 2 + rv_dly);
        check_val("rdata", got_rdata, exp_data);
        check_val("rresp", {30'd0, got_rresp}, 32'd0);
      end else begin
        check_val("rto_rvalid_lat", rv_seen, n_ar + 2 + TO);
        check_val("rto_rdata", got_rdata, 32'hDEAD_BEEF);
        check_val("rto_rresp", {30'd0, got_rresp}, 32'd2);
      end
    end
    check_val("rd_stable", {31'd0, unstable}, 32'd0);
    check_val("rd_no_extra", {31'd0, extra}, 32'd0);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return ($urandom & 32'hFFFC_0000) | 32'h0004_0000;
    return {26'd0, 4'($urandom), 2'($urandom)};
  endfunction

  logic [199:0] rst_vec;
  bit           stray;

  initial begin
    rst = 1; awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    bready = 0; araddr = 0; arprot = 0; arvalid = 0; rready = 0; RDAT = 0; RVLD = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_ready", {29'd0, awready, wready, arready}, 32'd0);
    rst_vec = {WREN, RDEN, bvalid, rvalid, WADR, RADR, WDAT, rdata, bresp, rresp, 94'd0};
    check_val("rst_outs_hi", rst_vec[199:168], 32'd0);
    check_val("rst_outs_lo", rst_vec[167:136], 32'd0);
    rst = 0;
    #1;
    check_val("ready_after_rst", {29'd0, awready, wready, arready}, 32'd7);
    @(negedge clk);

    // Directed scenarios
    write_txn(32'h0000_0010, 32'h1234_5678, 4'hF, 0, 0, -1);
    write_txn(32'h0000_0024, 32'hA5A5_0F0F, 4'hF, 5, 0, 3);
    write_txn(32'h0000_0030, 32'h1111_2222, 4'h3, 0, 1, 0);
    write_txn(32'h0004_0000, 32'h3333_4444, 4'hF, 2, 0, -1);
    regs[16'h0002] = 32'hCAFE_0001;
    read_txn(32'h0000_0008, 0, 3, -1);
    read_txn(32'h0000_000C, 1, -1, 0);
    read_txn(32'h0000_000C, 0, TO + 3, 0);
    read_txn(32'h0000_0004, 0, TO + 2, 4);
    read_txn(32'h0000_0008, 0, 0, 2);
    read_txn(32'h0000_0004, 0, TO, -1);
    read_txn(32'h0004_0000, 0, 0, -1);

    // Concurrent write and read: WREN and RDEN land in the same cycle
    fork
      write_txn(32'h0000_0040, 32'h0BAD_F00D, 4'hF, 0, 0, -1);
      read_txn(32'h0000_0010, 0, 2, -1);
    join
    check_val("wren_rden_same_cycle", wren_at, rden_at);

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0)
        write_txn(rand_addr(), $urandom,
                  ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF,
                  $urandom_range(0, 4), $urandom_range(0, 4),
                  int'($urandom_range(0, 4)) - 1);
      else
        read_txn(rand_addr(), $urandom_range(0, 3),
                 int'($urandom_range(0, TO + 4)) - 1,
                 int'($urandom_range(0, 4)) - 1);
    end

    // Reset mid-transaction: AW held, read parked in R_WAIT
    awaddr = 32'h0000_0050; awvalid = 1; araddr = 32'h0000_0020; arvalid = 1;
    @(negedge clk);
    awvalid = 0; arvalid = 0;
    check_val("abort_aw_held", {31'd0, awready}, 32'd0);
    check_val("abort_rden", {31'd0, RDEN}, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    check_val("abort_ready_forced", {29'd0, awready, wready, arready}, 32'd0);
    @(negedge clk);
    rst_vec = {WREN, RDEN, bvalid, rvalid, WADR, RADR, WDAT, rdata, bresp, rresp, 94'd0};
    check_val("abort_outs_hi", rst_vec[199:168], 32'd0);
    check_val("abort_outs_lo", rst_vec[167:136], 32'd0);
    rst = 0;
    #1;
    check_val("abort_ready_after", {29'd0, awready, wready, arready}, 32'd7);
    stray = 0;
    for (int i = 0; i < TO + 6; i++) begin
      RVLD = (i == 2);
      RDAT = 32'h7777_7777;
      if (WREN || RDEN || bvalid || rvalid) stray = 1;
      @(negedge clk);
    end
    RVLD = 0;
    check_val("abort_no_activity", {31'd0, stray}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
